// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader.
// Holds the instruction word geometry, the header sync nibble, the idle value
// driven to the CPU, the framer/issuer state encodings and a word-packing helper.
package instr_loader_pkg;

    localparam int INSTR_W = 20;
    localparam int OPC_W   = 4;
    localparam int OPND_W  = 16;

    localparam logic [3:0]         SYNC_NIB  = 4'hA;
    localparam logic [INSTR_W-1:0] IDLE_WORD = '0;

    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        F_HDR,
        F_OPH,
        F_OPL
    } framer_state_t;

    typedef enum logic {
        I_IDLE,
        I_HOLD
    } issuer_state_t;

    // Instruction layout: {opcode, operand_hi, operand_lo}.
    function automatic instr_t pack_instr(input logic [OPC_W-1:0] opc,
                                          input logic [7:0]       hi,
                                          input logic [7:0]       lo);
        return {opc, hi, lo};
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte link from the host and word link to the CPU.
//   in_valid / in_byte : host byte stream, driven by the host (master)
//   in_ready           : loader accepts the byte when in_valid && in_ready
//   cpu_data/cpu_valid : instruction word held for the CPU
// master = host/CPU side (testbench), slave = instr_loader.
interface instr_loader_if;
    import instr_loader_pkg::*;

    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;
    instr_t     cpu_data;
    logic       cpu_valid;

    modport master (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  cpu_data,
        input  cpu_valid
    );

    modport slave (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output cpu_data,
        output cpu_valid
    );

endinterface

// File: rtl/instr_loader_fifo.sv
// instr_fifo: circular-buffer FIFO for framed instruction words.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear (pointers and level), wins over push/pop
//   push, push_data   write one word (ignored when full)
//   pop, pop_data     pop_data shows the head word combinationally; pop advances it
//   full, empty       derived from the registered level
//   level             number of stored words
// Full/empty come from the registered level, so a word written at one edge is
// visible to the reader only from the next edge (no write-through bypass).
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_reg == FULL_LVL);
    assign empty    = (level_reg == '0);
    assign level    = level_reg;
    assign pop_data = mem[rd_ptr_reg];

    assign do_push = push && !full  && !flush;
    assign do_pop  = pop  && !empty && !flush;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so plain pointer increments wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + (AW+1)'(1);
                2'b01:   level_reg <= level_reg - (AW+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: frames a byte-serial host stream into 20-bit instructions
// {opcode[3:0], operand[15:0]} (3 bytes per packet, header byte[7:4] must be
// SYNC), buffers them in instr_fifo and holds each one on cpu_data for
// HOLD_CYCLES cycles.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         synchronous clear of FIFO, framer and issuer (err_count kept)
//   issue_stall   blocks the start of a new issue; never cuts a hold short
//   bus (slave)   in_valid/in_byte/in_ready host link, cpu_data/cpu_valid to CPU
//   fifo_level    words currently buffered
//   frame_err     one-cycle pulse after a bad header byte is accepted
//   err_count     saturating count of bad header bytes
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int         DEPTH       = 4,
    parameter int         HOLD_CYCLES = 3,
    parameter logic [3:0] SYNC        = SYNC_NIB,
    parameter instr_t     IDLE_WORD   = instr_loader_pkg::IDLE_WORD
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    issue_stall,
    instr_loader_if.slave           bus,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    frame_err,
    output logic [7:0]              err_count
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    framer_state_t       f_state_reg;
    logic [OPC_W-1:0]    opc_reg;
    logic [7:0]          hi_reg;
    logic                frame_err_reg;
    logic [7:0]          err_count_reg;

    issuer_state_t       i_state_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    instr_t              cpu_data_reg;
    logic                cpu_valid_reg;

    logic                fifo_full;
    logic                fifo_empty;
    instr_t              fifo_head;
    instr_t              push_word;
    logic                in_ready;
    logic                accept;
    logic                push;
    logic                at_boundary;
    logic                pop;

    // Header and high operand byte are always accepted; only the closing byte
    // needs FIFO room, so a push into a full FIFO can never be requested.
    assign in_ready  = !flush && ((f_state_reg != F_OPL) || !fifo_full);
    assign accept    = bus.in_valid && in_ready;
    assign push      = accept && (f_state_reg == F_OPL);
    assign push_word = pack_instr(opc_reg, hi_reg, bus.in_byte);

    // Issue decisions are made only when idle or on the last hold cycle, which
    // is where issue_stall is looked at. A word pushed at edge N is seen as
    // non-empty at edge N+1, so cpu_valid is first sampled high at edge N+2.
    assign at_boundary = (i_state_reg == I_IDLE) || (hold_cnt_reg == '0);
    assign pop         = !flush && at_boundary && !fifo_empty && !issue_stall;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Framer: HDR -> OPH -> OPL -> HDR, stepping only on accepted bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_state_reg   <= F_HDR;
            opc_reg       <= '0;
            hi_reg        <= '0;
            frame_err_reg <= 1'b0;
            err_count_reg <= '0;
        end else begin
            frame_err_reg <= 1'b0;
            if (flush) begin
                f_state_reg <= F_HDR;
            end else if (accept) begin
                case (f_state_reg)
                    F_HDR: begin
                        if (bus.in_byte[7:4] == SYNC) begin
                            opc_reg     <= bus.in_byte[3:0];
                            f_state_reg <= F_OPH;
                        end else begin
                            frame_err_reg <= 1'b1;
                            if (err_count_reg != 8'hFF) begin
                                err_count_reg <= err_count_reg + 8'd1;
                            end
                        end
                    end
                    F_OPH: begin
                        hi_reg      <= bus.in_byte;
                        f_state_reg <= F_OPL;
                    end
                    F_OPL: begin
                        f_state_reg <= F_HDR;
                    end
                    default: begin
                        f_state_reg <= F_HDR;
                    end
                endcase
            end
        end
    end

    // Issuer: a pop at a boundary reloads the hold counter, so back-to-back
    // words follow each other with no idle cycle in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_state_reg   <= I_IDLE;
            hold_cnt_reg  <= '0;
            cpu_data_reg  <= IDLE_WORD;
            cpu_valid_reg <= 1'b0;
        end else if (flush) begin
            i_state_reg   <= I_IDLE;
            hold_cnt_reg  <= '0;
            cpu_data_reg  <= IDLE_WORD;
            cpu_valid_reg <= 1'b0;
        end else if (pop) begin
            i_state_reg   <= I_HOLD;
            hold_cnt_reg  <= HOLD_LAST;
            cpu_data_reg  <= fifo_head;
            cpu_valid_reg <= 1'b1;
        end else if (i_state_reg == I_HOLD) begin
            if (hold_cnt_reg == '0) begin
                i_state_reg   <= I_IDLE;
                cpu_data_reg  <= IDLE_WORD;
                cpu_valid_reg <= 1'b0;
            end else begin
                hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.cpu_data  = cpu_data_reg;
    assign bus.cpu_valid = cpu_valid_reg;
    assign frame_err     = frame_err_reg;
    assign err_count     = err_count_reg;

endmodule
